uart_tx_fifo: RTL and testbench

Buffered UART transmitter: bytes written into an internal FIFO are serialised on `tx` as 8N1 frames (start bit, 8 data bits LSB first, stop bit). Bit timing uses the design's 16x oversampling convention: one baud tick every `baud_div` clocks, 16 ticks per bit. It sits beside the existing UART receiver and lets a host queue several bytes without waiting on a busy flag per byte.

---
 rtl/uart_tx_fifo.sv | 110 +++++++++++
 tb/tb_uart_tx_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 serialiser with 16x-oversampled bit timing.
module uart_tx_fifo #(
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        baud_div,
  input  logic [7:0]         wr_data,
  input  logic               wr_en,
  output logic               tx,
  output logic               tx_busy,
  output logic               tx_done,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   level,
  output logic               overflow
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};
  logic [7:0]         mem [1<<FIFO_AW];
  logic [FIFO_AW-1:0] rd_q, wr_q;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  state_e             st_q, st_d;
  logic [15:0]        div_q, div_d, tick_q, tick_d;
  logic [3:0]         sub_q, sub_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         sh_q, sh_d;
  logic               tx_q, busy_q, done_q, full_q, empty_q, ovf_q;
  logic               wr_ok, pop, tick, bit_end, tx_d, done_d;
  always_comb begin
    wr_ok   = wr_en && !full_q;
    tick    = st_q != IDLE && tick_q == div_q - 16'd1;
    bit_end = tick && sub_q == 4'd15;
    pop     = !empty_q && (st_q == IDLE || (st_q == STOP && bit_end));
    cnt_d   = cnt_q + {{FIFO_AW{1'b0}}, wr_ok} - {{FIFO_AW{1'b0}}, pop};
    st_d    = st_q;
    div_d   = div_q;
    tick_d  = (st_q == IDLE || tick) ? '0 : tick_q + 16'd1;
    sub_d   = tick ? sub_q + 4'd1 : sub_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    if (pop) begin
      st_d   = START;
      sh_d   = mem[rd_q];
      div_d  = baud_div == 16'd0 ? 16'd1 : baud_div;
      tick_d = '0;
      sub_d  = '0;
    end else if (bit_end) begin
      case (st_q)
        START: begin
          st_d  = DATA;
          idx_d = '0;
        end
        DATA: begin
          sh_d  = sh_q >> 1;
          idx_d = idx_q + 3'd1;
          st_d  = idx_q == 3'd7 ? STOP : DATA;
        end
        default: st_d = IDLE;
      endcase
    end
    tx_d   = st_d == START ? 1'b0 : st_d == DATA ? sh_d[0] : 1'b1;
    // Look one clock ahead so the registered pulse lands on the last stop-bit clock.
    done_d = st_d == STOP && sub_d == 4'd15 && tick_d == div_d - 16'd1;
  end
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_q] <= wr_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      st_q    <= IDLE;
      div_q   <= 16'd1;
      tick_q  <= '0;
      sub_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      rd_q    <= pop ? rd_q + 1'b1 : rd_q;
      wr_q    <= wr_ok ? wr_q + 1'b1 : wr_q;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      sub_q   <= sub_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= st_d != IDLE;
      done_q  <= done_d;
      full_q  <= cnt_d == DEPTH;
      empty_q <= cnt_d == '0;
      ovf_q   <= wr_en && full_q;
    end
  end
  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = cnt_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: queued expected frames are decoded off the serial line by an independent monitor.
module tb_uart_tx_fifo;
  logic clk = 0, rst_n = 0, wr_en = 0;
  logic [15:0] baud_div = 16'd5;
  logic [7:0] wr_data = 8'h00;
  logic tx, tx_busy, tx_done, full, empty, overflow;
  logic [3:0] level;
  typedef struct {logic [7:0] d; int p;} exp_t;
  exp_t sb[$];
  int cyc = 0, tests = 0, fails = 0, frames = 0, gap0 = 0, done_cnt = 0;
  bit mon_busy = 0;

  uart_tx_fifo #(.FIFO_AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .wr_data(wr_data), .wr_en(wr_en),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done), .full(full), .empty(empty),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic step_to(input int t, inout bit ab);
    while (cyc < t) begin
      @(negedge clk);
      if (!rst_n) ab = 1;
    end
  endtask

  // Receiver model: finds each start bit, samples mid-bit with the expected period.
  initial begin : mon
    int s, last_end;
    exp_t e;
    logic [9:0] bits;
    logic dn;
    bit ab;
    last_end = -1;
    forever begin
      mon_busy = 0;
      while (tx !== 1'b0 || !rst_n) @(negedge clk);
      mon_busy = 1;
      s = cyc;
      ab = 0;
      frames++;
      if (s == last_end) gap0++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frame: frame started at cycle %0d with nothing queued", s);
        e.d = 8'h00;
        e.p = 16;
      end else e = sb.pop_front();
      for (int k = 0; k < 10; k++) begin
        step_to(s + k * e.p + e.p / 2, ab);
        bits[k] = tx;
      end
      step_to(s + 10 * e.p - 1, ab);
      dn = tx_done;
      step_to(s + 10 * e.p, ab);
      last_end = ab ? -1 : s + 10 * e.p;
      if (!ab) begin
        chk("frame_bits", {22'd0, bits}, {22'd0, 1'b1, e.d, 1'b0});
        chk("done_timing", {31'd0, dn}, 32'd1);
      end
    end
  end

  task automatic put(input logic [7:0] d, input int p);
    sb.push_back(exp_t'{d, p});
    @(negedge clk);
    wr_data = d;
    wr_en = 1;
  endtask

  task automatic stop_wr();
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic drain(input int n);
    int i = 0;
    while ((sb.size() != 0 || mon_busy) && i < n) begin
      @(negedge clk);
      i++;
    end
    if (sb.size() != 0 || mon_busy) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d frames still pending after %0d cycles", sb.size(), n);
    end
  endtask

  initial begin
    int d0, g0, f0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_level", {28'd0, level}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1;
    // Single byte with latency checks
    d0 = done_cnt;
    put(8'hA5, 80);
    @(posedge clk) #1;
    chk("lat_empty", {31'd0, empty}, 32'd0);
    chk("lat_level", {28'd0, level}, 32'd1);
    chk("lat_tx_idle", {31'd0, tx}, 32'd1);
    @(negedge clk) wr_en = 0;
    @(posedge clk) #1;
    chk("lat_tx_start", {31'd0, tx}, 32'd0);
    chk("lat_busy", {31'd0, tx_busy}, 32'd1);
    chk("lat_pop_level", {28'd0, level}, 32'd0);
    drain(2000);
    chk("busy_after_done", {31'd0, tx_busy}, 32'd0);
    chk("single_done_cnt", done_cnt - d0, 32'd1);
    // Burst of three back-to-back
    d0 = done_cnt;
    g0 = gap0;
    put(8'h11, 80);
    put(8'h22, 80);
    put(8'h33, 80);
    stop_wr();
    drain(4000);
    chk("burst_contig", gap0 - g0, 32'd2);
    chk("burst_done_cnt", done_cnt - d0, 32'd3);
    chk("burst_empty", {31'd0, empty}, 32'd1);
    chk("burst_level", {28'd0, level}, 32'd0);
    // Overflow: ten writes into depth 8 with one pop in flight
    baud_div = 16'd1;
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) put(8'h40 + 8'(i), 16);
      else begin
        @(negedge clk);
        wr_data = 8'h49;
        wr_en = 1;
      end
      @(posedge clk) #1;
      if (i == 7) chk("ovf_not_full7", {31'd0, full}, 32'd0);
      if (i == 8) begin
        chk("ovf_full9", {31'd0, full}, 32'd1);
        chk("ovf_level9", {28'd0, level}, 32'd8);
        chk("ovf_none9", {31'd0, overflow}, 32'd0);
      end
      if (i == 9) begin
        chk("ovf_pulse", {31'd0, overflow}, 32'd1);
        chk("ovf_level10", {28'd0, level}, 32'd8);
      end
    end
    @(negedge clk) wr_en = 0;
    @(posedge clk) #1;
    chk("ovf_clear", {31'd0, overflow}, 32'd0);
    drain(3000);
    chk("ovf_done_cnt", done_cnt - d0, 32'd9);
    // Divisor zero acts as one
    baud_div = 16'd0;
    put(8'h3C, 16);
    stop_wr();
    drain(1000);
    // Divisor change mid-frame affects only the next frame
    baud_div = 16'd5;
    put(8'h5A, 80);
    put(8'hC3, 160);
    stop_wr();
    repeat (200) @(negedge clk);
    baud_div = 16'd10;
    drain(5000);
    // Reset during DATA with bytes queued
    baud_div = 16'd5;
    put(8'h81, 80);
    put(8'h7E, 80);
    put(8'h99, 80);
    stop_wr();
    repeat (300) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_level", {28'd0, level}, 32'd0);
    chk("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("mid_rst_empty", {31'd0, empty}, 32'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    f0 = frames;
    repeat (1000) @(negedge clk);
    chk("post_rst_no_frame", frames - f0, 32'd0);
    chk("post_rst_tx", {31'd0, tx}, 32'd1);
    chk("post_rst_busy", {31'd0, tx_busy}, 32'd0);
    // Loopback byte through the receiver model
    f0 = frames;
    put(8'hAA, 80);
    stop_wr();
    drain(2000);
    chk("loop_frames", frames - f0, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
